// File: rtl/cnn_layer_sequencer.sv
// Layer-by-layer controller for the conv -> maxpool datapath chain.
// Each stage is guarded by a watchdog; busy cycles are counted per run.
module cnn_layer_sequencer #(
    parameter int MAX_LAYERS     = 8,
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int CNT_WIDTH      = 32,
    localparam int LW = $clog2(MAX_LAYERS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  clear_err,
    input  logic [LW-1:0]         num_layers,
    input  logic [MAX_LAYERS-1:0] pool_mask,
    output logic                  dp_reset,
    output logic                  conv_en,
    input  logic                  done_conv,
    output logic                  pool_en,
    input  logic                  done_pool,
    output logic [LW-1:0]         layer_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  err_stage,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD, CONV, POOL, NEXT, DONE, ERROR
    } state_t;

    state_t                state;
    state_t                nxt;
    logic [LW-1:0]         nl_q;
    logic [MAX_LAYERS-1:0] pool_q;
    logic [CNT_WIDTH-1:0]  wd;
    logic [LW-1:0]         nl_eff;
    logic [MAX_LAYERS-1:0] pool_sh;
    logic                  wd_hit;
    logic                  last;
    logic                  st_busy;

    assign nl_eff  = (num_layers > LW'(MAX_LAYERS)) ? LW'(MAX_LAYERS) : num_layers;
    assign pool_sh = pool_q >> layer_idx;
    assign wd_hit  = (wd == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign last    = (layer_idx == nl_q - LW'(1));
    assign st_busy = (state == LOAD) || (state == CONV) ||
                     (state == POOL) || (state == NEXT);

    // A stage done beats a coincident timeout.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (start) nxt = (nl_eff == '0) ? DONE : LOAD;
            LOAD:  nxt = CONV;
            CONV: begin
                if (done_conv)   nxt = pool_sh[0] ? POOL : NEXT;
                else if (wd_hit) nxt = ERROR;
            end
            POOL: begin
                if (done_pool)   nxt = NEXT;
                else if (wd_hit) nxt = ERROR;
            end
            NEXT:  nxt = last ? DONE : LOAD;
            DONE:  nxt = IDLE;
            ERROR: if (clear_err) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            nl_q        <= '0;
            pool_q      <= '0;
            wd          <= '0;
            layer_idx   <= '0;
            cycle_count <= '0;
            dp_reset    <= 1'b0;
            conv_en     <= 1'b0;
            pool_en     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_stage   <= 1'b0;
        end else begin
            state    <= nxt;
            dp_reset <= (nxt == LOAD);
            conv_en  <= (nxt == CONV) || (nxt == POOL);
            pool_en  <= (nxt == POOL);
            busy     <= (nxt == LOAD) || (nxt == CONV) ||
                        (nxt == POOL) || (nxt == NEXT);
            done     <= (nxt == DONE);
            error    <= (nxt == ERROR);

            if (state == IDLE && nxt != IDLE) begin
                nl_q        <= nl_eff;
                pool_q      <= pool_mask;
                layer_idx   <= '0;
                cycle_count <= '0;
            end else if (st_busy && cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            end

            if (state == NEXT && nxt == LOAD)
                layer_idx <= layer_idx + LW'(1);

            if (nxt != state)
                wd <= '0;
            else if ((state == CONV || state == POOL) && wd != '1)
                wd <= wd + CNT_WIDTH'(1);

            if (nxt == IDLE)
                err_stage <= 1'b0;
            else if (nxt == ERROR && state != ERROR)
                err_stage <= (state == POOL);
        end
    end

endmodule
